// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU function codes, flag indices and controller state codes
package alu_pkg;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_TRANSX = 2'b10;
  localparam logic [1:0] ALU_COMP   = 2'b11;
  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_V = 2;
  localparam int FLG_S = 3;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_CAPT} state_t;
endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin pick; on a tie the requester not served last wins
module rr_arb2 (
  input  logic [1:0] eff,
  input  logic       last,
  output logic       win_valid,
  output logic       win_id
);
  // a lone request wins outright; a tie goes to the one served less recently
  always_comb begin
    win_valid = |eff;
    win_id    = &eff ? ~last : eff[1];
  end
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one registered ALU between two requesters
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int FLAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        op0,
  input  logic [1:0]        op1,
  input  logic [WIDTH-1:0]  a0,
  input  logic [WIDTH-1:0]  a1,
  input  logic [WIDTH-1:0]  b0,
  input  logic [WIDTH-1:0]  b1,
  output logic [1:0]        done,
  output logic [WIDTH-1:0]  resp_data,
  output logic [FLAG_W-1:0] resp_flags,
  output logic              busy,
  output logic              gnt_id,
  output logic [WIDTH-1:0]  alu_x,
  output logic [WIDTH-1:0]  alu_y,
  output logic [1:0]        alu_fun,
  input  logic [WIDTH-1:0]  alu_z,
  input  logic [FLAG_W-1:0] alu_flags
);
  state_t     state;
  logic       last;
  logic [1:0] eff;
  logic       win_valid;
  logic       win_id;

  // done is one-hot of gnt_id only in the cycle after CAPT, so it doubles as the stale-request mask
  always_comb eff = req & ~done;

  rr_arb2 u_arb (
    .eff       (eff),
    .last      (last),
    .win_valid (win_valid),
    .win_id    (win_id)
  );

  // grant in IDLE, let the ALU register during EXEC, capture its result in CAPT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      done       <= '0;
      busy       <= 1'b0;
      resp_data  <= '0;
      resp_flags <= '0;
      alu_x      <= '0;
      alu_y      <= '0;
      alu_fun    <= ALU_ADD;
      gnt_id     <= 1'b0;
      last       <= 1'b1;
    end else begin
      done <= '0;
      case (state)
        ST_IDLE: if (win_valid) begin
          alu_fun <= win_id ? op1 : op0;
          alu_x   <= win_id ? a1 : a0;
          alu_y   <= win_id ? b1 : b0;
          gnt_id  <= win_id;
          last    <= win_id;
          busy    <= 1'b1;
          state   <= ST_EXEC;
        end
        ST_EXEC: state <= ST_CAPT;
        ST_CAPT: begin
          resp_data  <= alu_z;
          resp_flags <= alu_flags;
          done       <= gnt_id ? 2'b10 : 2'b01;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
